mem_ctrl: RTL and testbench

- Memory-side responder for the committed-store handshake driven by the ROB (`rob_store_sgn` / `begin_real_store` / `finish_store`).
- Also services speculative load requests from the LSB.
- Serialises each access onto the byte-wide RAM/IO bus (`mem_a`, `mem_dout`, `mem_din`, `mem_wr`), little-endian.
- Sits between ROB/LSB and the top-level memory interface.

---
 rtl/mem_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- memory-side responder between the ROB/LSB and the byte-wide
// RAM/IO bus.
//
// Committed stores (from the ROB) and speculative loads (from the LSB) are
// serialised one byte per cycle onto mem_a/mem_dout/mem_din/mem_wr in
// little-endian order. Byte k of an access goes to addr+k, with 32-bit
// wrap-around.
//
// Handshakes:
//   rob_store_sgn is a level request. The store is taken on the first IDLE
//   edge that sees it. That edge raises begin_real_store for one cycle.
//   finish_store pulses for one cycle after the last byte has been written.
//   load_req is a level request, held until load_done. load_done is a
//   one-cycle pulse, and load_data is valid while it is high. A store request
//   beats a load request in the same cycle. A load is never accepted in a
//   cycle where rollback is high.
//
// Configuration:
//   `define MEMCTRL_IO_STALL_EN enables back-pressure from io_buffer_full.
//   With it, a store into IO space (addr[17:16] == IO_HI) holds its next byte
//   while the IO write buffer is full. Without it, io_buffer_full is ignored.
//
// Op encoding (6-bit, shared with the ROB/LSB):
//   LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8; any other value acts as a
//   1-byte access with a zero-extended result.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global ready; low freezes every register
//   rollback              misprediction flush (aborts a load, never a store)
//   rob_store_*           committed store request: sgn/op/addr/data
//   begin_real_store      store accepted pulse
//   finish_store          store completed pulse
//   load_req/op/addr      load request from the LSB
//   load_done, load_data  load completion pulse and extended result
//   mem_din               RAM read byte, valid the cycle after mem_a
//   mem_dout, mem_a,
//   mem_wr                byte bus toward RAM/IO
//   io_buffer_full        IO write buffer full (used only with the macro)
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        rob_store_sgn,
  input  logic [5:0]  rob_store_op,
  input  logic [31:0] rob_store_addr,
  input  logic [31:0] rob_store_data,
  output logic        begin_real_store,
  output logic        finish_store,
  input  logic        load_req,
  input  logic [5:0]  load_op,
  input  logic [31:0] load_addr,
  output logic        load_done,
  output logic [31:0] load_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  // Access length in bytes (1, 2 or 4).
  function automatic logic [2:0] len_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: len_of = 3'd1;
      OP_LH, OP_LHU, OP_SH: len_of = 3'd2;
      OP_LW, OP_SW:         len_of = 3'd4;
      default:              len_of = 3'd1;
    endcase
  endfunction

  // Sign/zero extension of the assembled little-endian value.
  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] v);
    case (op)
      OP_LB:   extend = {{24{v[7]}}, v[7:0]};
      OP_LH:   extend = {{16{v[15]}}, v[15:0]};
      OP_LHU:  extend = {16'h0000, v[15:0]};
      OP_LW:   extend = v;
      default: extend = {24'h000000, v[7:0]};
    endcase
  endfunction

  // Byte idx of a store data word.
  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = d[7:0];
      2'd1:    byte_of = d[15:8];
      2'd2:    byte_of = d[23:16];
      default: byte_of = d[31:24];
    endcase
  endfunction

  // Registered state (besides the output ports).
  state_t      state;
  logic [5:0]  op_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [2:0]  cnt;
  logic [31:0] acc;

  // Next values.
  state_t      state_nxt;
  logic [5:0]  op_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] data_nxt;
  logic [2:0]  cnt_nxt;
  logic [31:0] acc_nxt;
  logic        begin_nxt;
  logic        finish_nxt;
  logic        load_done_nxt;
  logic [31:0] load_data_nxt;
  logic [7:0]  mem_dout_nxt;
  logic [31:0] mem_a_nxt;
  logic        mem_wr_nxt;

  logic [2:0]  cur_len;
  logic [2:0]  cur_len_p1;
  logic        cur_is_io;
  logic        new_is_io;
  logic        stall_cur;
  logic        stall_new;

  assign cur_len    = len_of(op_r);
  assign cur_len_p1 = cur_len + 3'd1;
  assign cur_is_io  = (addr_r[17:16] == IO_HI);
  assign new_is_io  = (rob_store_addr[17:16] == IO_HI);

`ifdef MEMCTRL_IO_STALL_EN
  // stall_new covers the acceptance edge. Without it, byte 0 of an IO store
  // would reach the bus before the buffer-full check in STORE.
  assign stall_cur = io_buffer_full && cur_is_io;
  assign stall_new = io_buffer_full && new_is_io;
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ cur_is_io ^ new_is_io;
  assign stall_cur = 1'b0;
  assign stall_new = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register (plus all datapath/output registers).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      op_r             <= '0;
      addr_r           <= '0;
      data_r           <= '0;
      cnt              <= '0;
      acc              <= '0;
      begin_real_store <= 1'b0;
      finish_store     <= 1'b0;
      load_done        <= 1'b0;
      load_data        <= '0;
      mem_dout         <= '0;
      mem_a            <= '0;
      mem_wr           <= 1'b0;
    end else if (rdy) begin
      state            <= state_nxt;
      op_r             <= op_nxt;
      addr_r           <= addr_nxt;
      data_r           <= data_nxt;
      cnt              <= cnt_nxt;
      acc              <= acc_nxt;
      begin_real_store <= begin_nxt;
      finish_store     <= finish_nxt;
      load_done        <= load_done_nxt;
      load_data        <= load_data_nxt;
      mem_dout         <= mem_dout_nxt;
      mem_a            <= mem_a_nxt;
      mem_wr           <= mem_wr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rob_store_sgn)             state_nxt = S_STORE;
        else if (load_req && !rollback) state_nxt = S_LOAD;
      end
      S_STORE: begin
        // A committed store ignores rollback.
        if (!stall_cur && cnt >= cur_len) state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (rollback)                state_nxt = S_IDLE;
        else if (cnt == cur_len_p1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values.
  //
  // Load timing: the address for byte k is driven after edge T+k. The RAM
  // returns the byte one cycle later, so it is captured at edge T+k+2. The
  // cnt value at a LOAD edge therefore serves two roles: it is the next
  // address offset, and cnt-2 is the index of the byte being captured.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_nxt        = op_r;
    addr_nxt      = addr_r;
    data_nxt      = data_r;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    begin_nxt     = 1'b0;
    finish_nxt    = 1'b0;
    load_done_nxt = 1'b0;
    load_data_nxt = load_data;
    mem_dout_nxt  = mem_dout;
    mem_a_nxt     = mem_a;
    mem_wr_nxt    = mem_wr;

    case (state)
      S_IDLE: begin
        if (rob_store_sgn) begin
          op_nxt       = rob_store_op;
          addr_nxt     = rob_store_addr;
          data_nxt     = rob_store_data;
          begin_nxt    = 1'b1;
          mem_a_nxt    = rob_store_addr;
          mem_dout_nxt = rob_store_data[7:0];
          if (stall_new) begin
            // Byte 0 waits in STORE until the IO buffer drains.
            mem_wr_nxt = 1'b0;
            cnt_nxt    = 3'd0;
          end else begin
            mem_wr_nxt = 1'b1;
            cnt_nxt    = 3'd1;
          end
        end else if (load_req && !rollback) begin
          op_nxt     = load_op;
          addr_nxt   = load_addr;
          mem_wr_nxt = 1'b0;
          mem_a_nxt  = load_addr;
          cnt_nxt    = 3'd1;
          acc_nxt    = '0;
        end
      end

      S_STORE: begin
        if (stall_cur) begin
          mem_wr_nxt = 1'b0;
        end else if (cnt < cur_len) begin
          mem_wr_nxt   = 1'b1;
          mem_a_nxt    = addr_r + {29'd0, cnt};
          mem_dout_nxt = byte_of(data_r, cnt[1:0]);
          cnt_nxt      = cnt + 3'd1;
        end else begin
          mem_wr_nxt = 1'b0;
          mem_a_nxt  = '0;
          finish_nxt = 1'b1;
          cnt_nxt    = 3'd0;
        end
      end

      S_LOAD: begin
        if (rollback) begin
          // Flush: drop the in-flight load with no result.
          mem_a_nxt = '0;
          cnt_nxt   = 3'd0;
        end else begin
          case (cnt)
            3'd2:    acc_nxt[7:0]   = mem_din;
            3'd3:    acc_nxt[15:8]  = mem_din;
            3'd4:    acc_nxt[23:16] = mem_din;
            3'd5:    acc_nxt[31:24] = mem_din;
            default: ;
          endcase
          if (cnt < cur_len) begin
            mem_a_nxt = addr_r + {29'd0, cnt};
          end
          if (cnt == cur_len_p1) begin
            load_done_nxt = 1'b1;
            load_data_nxt = extend(op_r, acc_nxt);
            mem_a_nxt     = '0;
            cnt_nxt       = 3'd0;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- directed, self-checking bench for mem_ctrl.
// Driver tasks push the expected bus events, each stamped with its cycle,
// into exp_q. A separate monitor pops and compares every event the DUT shows:
// begin_real_store, each write, finish_store and load_done.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int W = 56; // {tag[3:0], cycle[11:0], addr_or_data[31:0], byte[7:0]}

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam logic [3:0] T_WR  = 4'd1;
  localparam logic [3:0] T_BEG = 4'd2;
  localparam logic [3:0] T_FIN = 4'd3;
  localparam logic [3:0] T_LD  = 4'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        rob_store_sgn = 1'b0;
  logic [5:0]  rob_store_op = '0;
  logic [31:0] rob_store_addr = '0;
  logic [31:0] rob_store_data = '0;
  logic        begin_real_store;
  logic        finish_store;
  logic        load_req = 1'b0;
  logic [5:0]  load_op = '0;
  logic [31:0] load_addr = '0;
  logic        load_done;
  logic [31:0] load_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  logic [11:0] cyc = 12'd0;
  always @(posedge clk) cyc <= cyc + 12'd1;

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rob_store_sgn(rob_store_sgn), .rob_store_op(rob_store_op),
    .rob_store_addr(rob_store_addr), .rob_store_data(rob_store_data),
    .begin_real_store(begin_real_store), .finish_store(finish_store),
    .load_req(load_req), .load_op(load_op), .load_addr(load_addr),
    .load_done(load_done), .load_data(load_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // ---------------- RAM model: registered read, one-cycle latency ----------
  logic [7:0] ram [0:1023];
  logic       pre_we = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (rdy && mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic push_evt(input logic [3:0] tag, input int c,
                          input logic [31:0] a, input logic [7:0] d);
    logic [11:0] c12;
    c12 = c[11:0];
    exp_q.push_back({tag, c12, a, d});
  endtask

  task automatic see_evt(input logic [3:0] tag, input logic [31:0] a, input logic [7:0] d);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {tag, cyc, a, d};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL unexpected_event tag=%0d cyc=%0d a=%h d=%h (nothing expected)",
               tag, cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        n_mis++;
        $display("FAIL event got tag=%0d cyc=%0d a=%h d=%h, expected tag=%0d cyc=%0d a=%h d=%h",
                 got[55:52], got[51:40], got[39:8], got[7:0],
                 e[55:52], e[51:40], e[39:8], e[7:0]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (begin_real_store) see_evt(T_BEG, 32'h0, 8'h00);
        if (mem_wr)           see_evt(T_WR, mem_a, mem_dout);
        if (finish_store)     see_evt(T_FIN, 32'h0, 8'h00);
        if (load_done)        see_evt(T_LD, load_data, 8'h00);
      end
    end
  end

  // ---------------- driver tasks (each starts and ends on a negedge) -------
  task automatic set_ram(input logic [9:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // n-byte store. rb_at >= 0 raises rollback for one edge in the middle.
  task automatic do_store(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int n, input int rb_at);
    int a_edge;
    logic [31:0] sh;
    a_edge = int'(cyc) + 1;
    rob_store_sgn = 1'b1; rob_store_op = op;
    rob_store_addr = addr; rob_store_data = data;
    push_evt(T_BEG, a_edge, 32'h0, 8'h00);
    for (int k = 0; k < n; k++) begin
      sh = data >> (8 * k);
      push_evt(T_WR, a_edge + k, addr + k, sh[7:0]);
    end
    push_evt(T_FIN, a_edge + n, 32'h0, 8'h00);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i == 0) rob_store_sgn = 1'b0;
      rollback = (i == rb_at);
    end
    rollback = 1'b0;
  endtask

  // Load with hand-computed result and latency. With rb_first, rollback is
  // high on the first edge, so acceptance slips by one edge.
  task automatic do_load(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] exp_data, input int lat, input bit rb_first);
    int a_edge;
    bit seen;
    a_edge = int'(cyc) + 1 + (rb_first ? 1 : 0);
    load_req = 1'b1; load_op = op; load_addr = addr; rollback = rb_first;
    push_evt(T_LD, a_edge + lat, exp_data, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      rollback = 1'b0;
      if (load_done) seen = 1'b1;
    end
    load_req = 1'b0;
    if (!seen) begin
      n_cmp++; n_mis++;
      $display("FAIL load_timeout got no load_done expected one within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_begin"}, {31'd0, begin_real_store}, 32'd0);
    chk({tag, "_finish"}, {31'd0, finish_store}, 32'd0);
    chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
    chk({tag, "_mem_a"}, mem_a, 32'd0);
    chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a_edge;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("reset");
    @(negedge clk);

    // SW 0x11223344 @ 0x100: 4 writes, then finish_store.
    do_store(OP_SW, 32'h0000_0100, 32'h1122_3344, 4, -1);

    // Byte loads.
    set_ram(10'h200, 8'h80);
    do_load(OP_LB,  32'h0000_0200, 32'hFFFF_FF80, 2, 1'b0);
    do_load(OP_LBU, 32'h0000_0200, 32'h0000_0080, 2, 1'b0);

    // Halfword loads. LHU starts under rollback, so it is accepted one edge late.
    set_ram(10'h300, 8'h34);
    set_ram(10'h301, 8'h82);
    do_load(OP_LH,  32'h0000_0300, 32'hFFFF_8234, 3, 1'b0);
    do_load(OP_LHU, 32'h0000_0300, 32'h0000_8234, 3, 1'b1);

    // Word load.
    set_ram(10'h300, 8'h78);
    set_ram(10'h301, 8'h56);
    set_ram(10'h302, 8'h34);
    set_ram(10'h303, 8'h12);
    do_load(OP_LW, 32'h0000_0300, 32'h1234_5678, 5, 1'b0);

    // Unknown op: one byte, zero-extended.
    do_load(6'd0, 32'h0000_0300, 32'h0000_0078, 2, 1'b0);

    // Store and load together: SB wins, the load follows after finish_store.
    a_edge = int'(cyc) + 1;
    rob_store_sgn = 1'b1; rob_store_op = OP_SB;
    rob_store_addr = 32'h0000_0010; rob_store_data = 32'h0000_00A5;
    load_req = 1'b1; load_op = OP_LB; load_addr = 32'h0000_0200;
    push_evt(T_BEG, a_edge, 32'h0, 8'h00);
    push_evt(T_WR, a_edge, 32'h0000_0010, 8'hA5);
    push_evt(T_FIN, a_edge + 1, 32'h0, 8'h00);
    push_evt(T_LD, a_edge + 4, 32'hFFFF_FF80, 8'h00);
    @(negedge clk);
    rob_store_sgn = 1'b0;
    for (int i = 0; i < 20 && !load_done; i++) @(negedge clk);
    if (!load_done) begin
      n_cmp++; n_mis++;
      $display("FAIL arb_load_timeout got no load_done expected one");
    end
    load_req = 1'b0;
    @(negedge clk);

    // Rollback in cycle 2 of an LW: no result, bus address cleared.
    a_edge = int'(cyc) + 1;
    load_req = 1'b1; load_op = OP_LW; load_addr = 32'h0000_0300;
    @(negedge clk);
    @(negedge clk);
    rollback = 1'b1; load_req = 1'b0;
    @(negedge clk);
    rollback = 1'b0;
    chk("rollback_mem_a", mem_a, 32'h0);
    chk("rollback_load_done", {31'd0, load_done}, 32'd0);
    repeat (6) @(negedge clk);
    // Idle again: the next load is accepted immediately.
    do_load(OP_LB, 32'h0000_0200, 32'hFFFF_FF80, 2, 1'b0);

    // Rollback during SW: the committed store still completes.
    do_store(OP_SW, 32'h0000_0100, 32'hCAFE_F00D, 4, 1);

    // SH that wraps past 0xFFFFFFFF.
    do_store(OP_SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, -1);

    // SB into IO space while the IO buffer is full for 3 edges.
    a_edge = int'(cyc) + 1;
    rob_store_sgn = 1'b1; rob_store_op = OP_SB;
    rob_store_addr = 32'h0003_0000; rob_store_data = 32'h0000_005A;
    io_buffer_full = 1'b1;
    push_evt(T_BEG, a_edge, 32'h0, 8'h00);
`ifdef MEMCTRL_IO_STALL_EN
    push_evt(T_WR, a_edge + 3, 32'h0003_0000, 8'h5A);
    push_evt(T_FIN, a_edge + 4, 32'h0, 8'h00);
`else
    push_evt(T_WR, a_edge, 32'h0003_0000, 8'h5A);
    push_evt(T_FIN, a_edge + 1, 32'h0, 8'h00);
`endif
    @(negedge clk);
    rob_store_sgn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    io_buffer_full = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of an LW: every output clears, no result.
    load_req = 1'b1; load_op = OP_LW; load_addr = 32'h0000_0300;
    @(negedge clk);
    rst = 1'b1; load_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("midreset");
    repeat (8) @(negedge clk);

    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_cmp++; n_mis++;
      $display("FAIL missing_event got none expected tag=%0d cyc=%0d a=%h d=%h",
               e[55:52], e[51:40], e[39:8], e[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
